// File: rtl/vga_capture.sv
// VGA stream receiver: measures incoming timing, locks after two matching frames,
// and stores one sample per SCALE x SCALE block into an OUT_W x OUT_H frame memory.
module vga_capture #(
  parameter int unsigned SCALE  = 10,
  parameter int unsigned OUT_W  = 192,
  parameter int unsigned OUT_H  = 108,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_hs,
  input  logic              vga_vs,
  input  logic              vga_de,
  input  logic [7:0]        vga_r,
  input  logic [7:0]        vga_g,
  input  logic [7:0]        vga_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic [11:0]       h_total_meas,
  output logic [11:0]       h_active_meas,
  output logic [11:0]       v_total_meas,
  output logic [11:0]       v_active_meas,
  output logic              locked,
  output logic              frame_done
);

  localparam int unsigned CNT_W = 12;
  localparam int unsigned SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned COL_W = $clog2(OUT_W + 1);
  localparam int unsigned ROW_W = $clog2(OUT_H + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] SEEK    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] VERIFY  = 2'd2;
  localparam logic [1:0] CAPTURE = 2'd3;

  logic              s1_hs, s1_vs, s1_de, s2_hs, s2_vs, s2_de;
  logic [23:0]       s1_rgb;
  logic              vs_fall, hs_fall, de_rise, de_fall;
  logic [CNT_W-1:0]  h_cnt, de_cnt, v_cnt, v_act_cnt;
  logic [1:0]        state, state_nxt;
  logic              locked_nxt, frame_done_nxt, match;
  logic [CNT_W-1:0]  ref_h_active, ref_v_active, ref_h_nxt, ref_v_nxt;
  logic [SUB_W-1:0]  col_sub, row_sub, col_sub_cur, row_sub_cur;
  logic [COL_W-1:0]  col, col_cur;
  logic [ROW_W-1:0]  row, row_cur;
  logic [ADDR_W-1:0] row_base, row_base_cur;
  logic              sample;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Two-stage input pipeline; edges come from s1 against s2
  always_ff @(posedge clk) begin
    if (reset) begin
      {s1_hs, s1_vs, s1_de, s2_hs, s2_vs, s2_de} <= '0;
      s1_rgb <= '0;
    end else begin
      {s1_hs, s1_vs, s1_de} <= {vga_hs, vga_vs, vga_de};
      {s2_hs, s2_vs, s2_de} <= {s1_hs, s1_vs, s1_de};
      s1_rgb <= {vga_r, vga_g, vga_b};
    end
  end

  assign vs_fall = s2_vs & ~s1_vs;
  assign hs_fall = s2_hs & ~s1_hs;
  assign de_rise = s1_de & ~s2_de;
  assign de_fall = s2_de & ~s1_de;

  // Saturating timing measurement
  always_ff @(posedge clk) begin
    if (reset) begin
      {h_cnt, de_cnt, v_cnt, v_act_cnt} <= '0;
      {h_total_meas, h_active_meas, v_total_meas, v_active_meas} <= '0;
    end else begin
      if (hs_fall) begin
        h_total_meas <= h_cnt;
        h_cnt        <= CNT_W'(1);
      end else begin
        h_cnt <= sat_inc(h_cnt);
      end
      if (de_rise)    de_cnt <= CNT_W'(1);
      else if (s1_de) de_cnt <= sat_inc(de_cnt);
      if (de_fall) h_active_meas <= de_cnt;
      if (vs_fall) begin
        v_total_meas  <= v_cnt;
        v_cnt         <= hs_fall ? CNT_W'(1) : '0;
        v_active_meas <= v_act_cnt;
        v_act_cnt     <= '0;
      end else begin
        if (hs_fall) v_cnt     <= sat_inc(v_cnt);
        if (de_fall) v_act_cnt <= sat_inc(v_act_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SEEK;
      locked       <= 1'b0;
      frame_done   <= 1'b0;
      ref_h_active <= '0;
      ref_v_active <= '0;
    end else begin
      state        <= state_nxt;
      locked       <= locked_nxt;
      frame_done   <= frame_done_nxt;
      ref_h_active <= ref_h_nxt;
      ref_v_active <= ref_v_nxt;
    end
  end

  // Lock sequencing: everything happens at the frame boundary
  always_comb begin
    state_nxt      = state;
    locked_nxt     = locked;
    frame_done_nxt = 1'b0;
    ref_h_nxt      = ref_h_active;
    ref_v_nxt      = ref_v_active;
    match          = (h_active_meas == ref_h_active) && (v_act_cnt == ref_v_active);
    if (vs_fall) begin
      case (state)
        SEEK: state_nxt = MEASURE;
        MEASURE: begin
          ref_h_nxt = h_active_meas;
          ref_v_nxt = v_act_cnt;
          state_nxt = VERIFY;
        end
        VERIFY: begin
          if (match) begin
            state_nxt  = CAPTURE;
            locked_nxt = 1'b1;
          end else begin
            ref_h_nxt = h_active_meas;
            ref_v_nxt = v_act_cnt;
          end
        end
        CAPTURE: begin
          frame_done_nxt = 1'b1;
          if (!match) begin
            state_nxt  = VERIFY;
            locked_nxt = 1'b0;
          end
        end
        default: state_nxt = SEEK;
      endcase
    end
  end

  // Frame/line restarts take effect in the same cycle as the edge
  always_comb begin
    col_sub_cur  = de_rise ? '0 : col_sub;
    col_cur      = de_rise ? '0 : col;
    row_sub_cur  = vs_fall ? '0 : row_sub;
    row_cur      = vs_fall ? '0 : row;
    row_base_cur = vs_fall ? '0 : row_base;
    sample = (state_nxt == CAPTURE) && s1_de && (col_sub_cur == '0) && (row_sub_cur == '0) &&
             (col_cur < COL_W'(OUT_W)) && (row_cur < ROW_W'(OUT_H));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_sub  <= '0;
      col      <= '0;
      row_sub  <= '0;
      row      <= '0;
      row_base <= '0;
    end else begin
      if (s1_de) begin
        if (col_sub_cur == SUB_W'(SCALE - 1)) begin
          col_sub <= '0;
          col     <= (col_cur < COL_W'(OUT_W)) ? col_cur + COL_W'(1) : col_cur;
        end else begin
          col_sub <= col_sub_cur + SUB_W'(1);
          col     <= col_cur;
        end
      end
      if (vs_fall) begin
        row_sub  <= '0;
        row      <= '0;
        row_base <= '0;
      end else if (de_fall) begin
        if (row_sub == SUB_W'(SCALE - 1)) begin
          row_sub <= '0;
          if (row < ROW_W'(OUT_H)) begin
            row      <= row + ROW_W'(1);
            row_base <= row_base + ADDR_W'(OUT_W);
          end
        end else begin
          row_sub <= row_sub + SUB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= sample;
      if (sample) begin
        wr_addr <= row_base_cur + ADDR_W'(col_cur);
        wr_data <= s1_rgb;
      end
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Randomized bench for vga_capture against a frame-level reference model.
module tb_vga_capture;

  localparam int unsigned SCALE  = 10;
  localparam int unsigned OUT_W  = 4;
  localparam int unsigned OUT_H  = 2;
  localparam int unsigned ADDR_W = 3;
  localparam int H_TOT    = 100;
  localparam int V_TOT    = 30;
  localparam int V_ACT    = 20;
  localparam int DE_START = 10;
  localparam int HS_LEN   = 8;
  localparam int VS_LINES = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vga_hs = 1'b1, vga_vs = 1'b1, vga_de = 1'b0;
  logic [7:0] vga_r = '0, vga_g = '0, vga_b = '0;
  logic wr_en, locked, frame_done;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0] wr_data;
  logic [11:0] h_total_meas, h_active_meas, v_total_meas, v_active_meas;

  always #5 clk = ~clk;

  vga_capture #(.SCALE(SCALE), .OUT_W(OUT_W), .OUT_H(OUT_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .h_total_meas(h_total_meas), .h_active_meas(h_active_meas),
    .v_total_meas(v_total_meas), .v_active_meas(v_active_meas),
    .locked(locked), .frame_done(frame_done)
  );

  typedef struct {
    int                due;
    logic [ADDR_W-1:0] addr;
    logic [23:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int total = 0, bad = 0, cyc = 0;
  logic [ADDR_W-1:0] hold_addr = '0;
  logic [23:0] hold_data = '0;
  logic lk_exp = 1'b0, lk_val = 1'b0, prev_vs = 1'b0;
  int lk_due = -1, fd_due = -1, meas_due = -1, zero_due = -1, meas_w = 0;

  // Frame-level model: 0 seek, 1 measure, 2 verify, 3 capture
  int m_st = 0, ref_w = 0, last_w = 0;
  bit full_prev = 1'b0, capturing = 1'b0;
  logic m_locked = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic exp_en;
    wr_t w;
    exp_en = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      w = exp_q.pop_front();
      exp_en = 1'b1;
      hold_addr = w.addr;
      hold_data = w.data;
    end
    if (lk_due == cyc) lk_exp = lk_val;
    check("wr_en", 32'(wr_en), 32'(exp_en));
    check("wr_addr", 32'(wr_addr), 32'(hold_addr));
    check("wr_data", 32'(wr_data), 32'(hold_data));
    check("locked", 32'(locked), 32'(lk_exp));
    check("frame_done", 32'(frame_done), 32'(fd_due == cyc));
    if (meas_due == cyc) begin
      check("h_total", 32'(h_total_meas), 32'(H_TOT));
      check("h_active", 32'(h_active_meas), 32'(meas_w));
      check("v_total", 32'(v_total_meas), 32'(V_TOT));
      check("v_active", 32'(v_active_meas), 32'(V_ACT));
    end
    if (zero_due == cyc) begin
      check("rst_h_total", 32'(h_total_meas), 32'd0);
      check("rst_h_active", 32'(h_active_meas), 32'd0);
      check("rst_v_total", 32'(v_total_meas), 32'd0);
      check("rst_v_active", 32'(v_active_meas), 32'd0);
    end
  endtask

  task automatic on_vs_fall();
    bit meas_ok;
    meas_ok = full_prev;
    case (m_st)
      0: m_st = 1;
      1: begin ref_w = last_w; m_st = 2; end
      2: begin
        if (last_w == ref_w) begin m_st = 3; m_locked = 1'b1; end
        else ref_w = last_w;
      end
      default: begin
        fd_due = cyc + 2;
        if (last_w != ref_w) begin m_st = 2; m_locked = 1'b0; end
      end
    endcase
    lk_due = cyc + 2;
    lk_val = m_locked;
    if (meas_ok) begin meas_due = cyc + 2; meas_w = last_w; end
    full_prev = 1'b1;
    capturing = (m_st == 3);
  endtask

  task automatic tick(input logic hs, input logic vs, input logic de, input logic [23:0] px,
                      input logic rst, input int line, input int h);
    int p;
    wr_t w;
    @(negedge clk);
    cyc++;
    check_outputs();
    reset = rst;
    vga_hs = hs;
    vga_vs = vs;
    vga_de = de;
    {vga_r, vga_g, vga_b} = px;
    if (rst) begin
      exp_q.delete();
      m_st = 0; m_locked = 1'b0; capturing = 1'b0; full_prev = 1'b0;
      lk_exp = 1'b0; lk_due = -1; fd_due = -1; meas_due = -1;
      hold_addr = '0; hold_data = '0;
      zero_due = cyc + 1;
    end else begin
      if (prev_vs && !vs) on_vs_fall();
      if (de && capturing) begin
        p = h - DE_START;
        if (p % SCALE == 0 && line % SCALE == 0 && p / SCALE < OUT_W && line / SCALE < OUT_H) begin
          w.due  = cyc + 2;
          w.addr = ADDR_W'((line / SCALE) * OUT_W + p / SCALE);
          w.data = px;
          exp_q.push_back(w);
        end
      end
    end
    prev_vs = rst ? 1'b0 : vs;
  endtask

  task automatic run_frame(input int w, input int rst_line, input int nlines, input bit rnd_blue);
    logic hs, vs, de;
    logic [7:0] blue;
    int pos;
    for (int line = 0; line < nlines; line++) begin
      for (int h = 0; h < H_TOT; h++) begin
        pos  = line * H_TOT + h;
        hs   = !(h < HS_LEN);
        vs   = !(pos >= DE_START && pos < DE_START + VS_LINES * H_TOT);
        de   = (line < V_ACT) && (h >= DE_START) && (h < DE_START + w);
        blue = rnd_blue ? 8'($urandom) : 8'h5A;
        tick(hs, vs, de, {8'(line), 8'(h), blue}, (line == rst_line && h == 0), line, h);
      end
    end
    last_w = w;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 24'h0, 1'b1, 0, 0);
    for (int i = 0; i < int'($urandom_range(5, 20)); i++) tick(1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 0, 0);
    // lock on three identical frames, then capture
    for (int f = 0; f < 3; f++) run_frame(40, -1, V_TOT, 1'b0);
    // overscan: wider active region after lock
    for (int f = 0; f < 3; f++) run_frame(60, -1, V_TOT, 1'b0);
    // reset mid-way through a captured frame
    run_frame(60, 12, V_TOT, 1'b0);
    for (int f = 0; f < 3; f++) run_frame(40, -1, V_TOT, 1'b0);
    for (int f = 0; f < 4; f++) run_frame(40 + 10 * int'($urandom_range(0, 2)), -1, V_TOT, 1'b1);
    run_frame(40, -1, 1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 0, 0);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
